// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the badge UART command initiator.
package uart_cmd_pkg;

  localparam int FRAME_BYTES   = 18;
  localparam int PAYLOAD_BYTES = 16;
  localparam int FRAME_BITS    = FRAME_BYTES * 8;
  localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;

  localparam logic [7:0] OP_SHOOTING_FLAGS = 8'h41;
  localparam logic [7:0] OP_SEND_TX        = 8'h40;
  localparam logic [7:0] OP_AES_KEY        = 8'h42;
  localparam logic [7:0] OP_AES_PT         = 8'h43;
  localparam logic [7:0] OP_PRIV_EXEC      = 8'h44;
  localparam logic [7:0] OP_DEV_ADDR       = 8'h61;
  localparam logic [7:0] OP_DEV_READ       = 8'h62;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_RESP,
    S_DONE
  } state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: baud counter plus start/data/stop shifter.
module uart_tx_byte #(
  parameter int BIT_CLKS = 10752
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       line,
  output logic       tick,
  output logic       byte_done
);

  localparam int BW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CLKS - 1);
  localparam logic [3:0] STOP_BIT = 4'd9;

  logic          active_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;
  logic          line_q;

  assign tick      = active_q && (baud_q == BAUD_LAST);
  assign byte_done = tick && (bit_q == STOP_BIT);
  assign line      = line_q;

  // start may land on the byte_done cycle so bytes chain with no gap
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      line_q   <= 1'b1;
    end else if (start) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, byte_in};
      line_q   <= 1'b0;
    end else if (tick) begin
      baud_q <= '0;
      if (bit_q == STOP_BIT) begin
        active_q <= 1'b0;
        line_q   <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        line_q  <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
      end
    end else if (active_q) begin
      baud_q <= baud_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_initiator.sv
// Badge UART command initiator: sends opcode, 16 payload bytes, opcode endchar as 8N1.
// Define CMD_RESP_WAIT_EN to also collect an 18-byte reply with an inter-byte timeout.
module uart_cmd_initiator
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ     = 103_340_000,
  parameter int BIT_CLKS     = 10752,
  parameter int TIMEOUT_CLKS = CLK_FREQ / 25
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_opcode,
  input  logic [PAYLOAD_BITS-1:0] cmd_payload,
  output logic                    tx,
  output logic                    busy,
  output logic                    done,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_byte_valid,
  output logic [FRAME_BITS-1:0]   resp_frame,
  output logic                    resp_valid,
  output logic                    resp_timeout
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [4:0] LAST_BYTE = 5'(FRAME_BYTES - 1);

  state_e                state_q;
  logic [2:0]            bit_q;
  logic [4:0]            byte_q;
  logic [FRAME_BITS-9:0] frame_q;
  logic                  busy_q;
  logic                  done_q;

  logic       accept;
  logic       next_byte;
  logic       tx_start;
  logic       tx_tick;
  logic       tx_byte_done;
  logic [7:0] tx_data;

`ifdef CMD_RESP_WAIT_EN
  logic [FRAME_BITS-1:0] resp_frame_q;
  logic [4:0]            ridx_q;
  logic [TW-1:0]         tcnt_q;
  logic                  resp_valid_q;
  logic                  resp_timeout_q;

  assign resp_frame   = resp_frame_q;
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
`else
  logic unused_cfg;

  assign unused_cfg   = ^{rx_byte, rx_byte_valid, TO_LAST};
  assign resp_frame   = '0;
  assign resp_valid   = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign next_byte = (state_q == S_STOP) && tx_byte_done
                     && (byte_q != LAST_BYTE);
  assign tx_start  = accept || next_byte;
  assign tx_data   = accept ? cmd_opcode : frame_q[7:0];
  assign busy      = busy_q;
  assign done      = done_q;

  uart_tx_byte #(
    .BIT_CLKS (BIT_CLKS)
  ) u_tx (
    .clk       (clk),
    .nreset    (nreset),
    .start     (tx_start),
    .byte_in   (tx_data),
    .line      (tx),
    .tick      (tx_tick),
    .byte_done (tx_byte_done)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CMD_RESP_WAIT_EN
      resp_frame_q   <= '0;
      ridx_q         <= '0;
      tcnt_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CMD_RESP_WAIT_EN
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            // byte0 goes straight to the serialiser; endchar repeats opcode
            frame_q <= {cmd_opcode, cmd_payload};
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_tick) begin
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_tick) begin
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (tx_byte_done) begin
            if (byte_q == LAST_BYTE) begin
`ifdef CMD_RESP_WAIT_EN
              resp_frame_q <= '0;
              ridx_q       <= '0;
              tcnt_q       <= '0;
              state_q      <= S_WAIT_RESP;
`else
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
`endif
            end else begin
              byte_q  <= byte_q + 5'd1;
              frame_q <= {8'h00, frame_q[FRAME_BITS-9:8]};
              state_q <= S_START;
            end
          end
        end
        S_WAIT_RESP: begin
`ifdef CMD_RESP_WAIT_EN
          // a byte landing on the timeout cycle takes priority
          if (rx_byte_valid) begin
            resp_frame_q[{ridx_q, 3'b000} +: 8] <= rx_byte;
            ridx_q <= ridx_q + 5'd1;
            tcnt_q <= '0;
            if (ridx_q == LAST_BYTE) begin
              resp_valid_q <= 1'b1;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= S_DONE;
            end
          end else if (tcnt_q == TO_LAST) begin
            resp_timeout_q <= 1'b1;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_DONE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Bench for uart_cmd_initiator: bit-timeline reference model of the 8N1 command frame.
module tb_uart_cmd_initiator;

  localparam int B          = 4;
  localparam int TO         = 100;
  localparam int FB         = 18;
  localparam int FRAME_CLKS = 180 * B;
`ifdef CMD_RESP_WAIT_EN
  localparam int DONE_J = FRAME_CLKS + TO;
`else
  localparam int DONE_J = FRAME_CLKS;
`endif
  localparam int MAXJ = DONE_J + 1 + 4 * B;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode = 8'h00;
  logic [127:0] cmd_payload = '0;
  logic         tx;
  logic         busy;
  logic         done;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_byte_valid = 1'b0;
  logic [143:0] resp_frame;
  logic         resp_valid;
  logic         resp_timeout;

  int total = 0;
  int bad = 0;

  logic       txs [0:MAXJ];
  logic [7:0] reply_b [FB];
  logic [7:0] ops [7];

  always #5 clk = ~clk;

  uart_cmd_initiator #(
    .CLK_FREQ     (2500),
    .BIT_CLKS     (B),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_payload   (cmd_payload),
    .tx            (tx),
    .busy          (busy),
    .done          (done),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .resp_frame    (resp_frame),
    .resp_valid    (resp_valid),
    .resp_timeout  (resp_timeout)
  );

  function automatic logic [127:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    int n_tx, n_busy, n_rdy, n_done, n_resp;
    n_tx = 0; n_busy = 0; n_rdy = 0; n_done = 0; n_resp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n_tx++;
      if (busy !== 1'b0) n_busy++;
      if (cmd_ready !== 1'b1) n_rdy++;
      if (done !== 1'b0) n_done++;
      if (resp_valid !== 1'b0 || resp_timeout !== 1'b0 ||
          resp_frame !== '0) n_resp++;
    end
    total++; if (n_tx != 0) begin bad++; $display("FAIL reset_tx bad_cycles=%0d want 0", n_tx); end
    total++; if (n_busy != 0) begin bad++; $display("FAIL reset_busy bad_cycles=%0d want 0", n_busy); end
    total++; if (n_rdy != 0) begin bad++; $display("FAIL reset_ready bad_cycles=%0d want 0", n_rdy); end
    total++; if (n_done != 0) begin bad++; $display("FAIL reset_done bad_cycles=%0d want 0", n_done); end
    total++; if (n_resp != 0) begin bad++; $display("FAIL reset_resp bad_cycles=%0d want 0", n_resp); end
    nreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sends one command and checks the whole tx/busy/done/ready timeline.
  task automatic run_frame(input string name, input logic [7:0] op,
                           input logic [127:0] pl, input bit inject);
    logic [7:0] exp_b [FB];
    logic [7:0] got;
    logic       e;
    int n, k, t, idx;
    int n_tx, n_busy, n_rdy, n_done, done_at, n_rv, n_to;
    exp_b[0] = op;
    for (int i = 1; i <= 16; i++) exp_b[i] = pl[(i-1)*8 +: 8];
    exp_b[17] = op;
    n_tx = 0; n_busy = 0; n_rdy = 0; n_done = 0; done_at = -1;
    n_rv = 0; n_to = 0;
    cmd_opcode = op; cmd_payload = pl; cmd_valid = 1'b1;
    for (int j = 0; j <= MAXJ; j++) begin
      @(negedge clk);
      txs[j] = tx;
      if (j < FRAME_CLKS) begin
        n = j / B; k = n / 10; t = n % 10;
        if (t == 0) e = 1'b0;
        else if (t == 9) e = 1'b1;
        else e = exp_b[k][t-1];
      end else begin
        e = 1'b1;
      end
      if (tx !== e) n_tx++;
      if (busy !== (j < DONE_J)) n_busy++;
      if (cmd_ready !== (j > DONE_J)) n_rdy++;
      if (done === 1'b1) begin n_done++; done_at = j; end
      if (resp_valid !== 1'b0) n_rv++;
      if (resp_timeout !== (j == DONE_J) && DONE_J != FRAME_CLKS) n_to++;
      if (j == 0) cmd_valid = 1'b0;
      if (inject && j == 10) begin
        cmd_opcode = ~op; cmd_payload = ~pl; cmd_valid = 1'b1;
      end
      if (inject && j == 14) cmd_valid = 1'b0;
      if (inject && j == 20) begin rx_byte = 8'hFF; rx_byte_valid = 1'b1; end
      if (inject && j == 21) rx_byte_valid = 1'b0;
    end
    for (int kb = 0; kb < FB; kb++) begin
      for (int b = 1; b <= 8; b++) begin
        idx = (kb * 10 + b) * B + B / 2;
        got[b-1] = txs[idx];
      end
      total++;
      if (got !== exp_b[kb]) begin
        bad++;
        $display("FAIL %s byte%0d got=%h want=%h", name, kb, got, exp_b[kb]);
      end
    end
    total++; if (n_tx != 0) begin bad++; $display("FAIL %s tx_timeline bad_cycles=%0d want 0", name, n_tx); end
    total++; if (n_busy != 0) begin bad++; $display("FAIL %s busy bad_cycles=%0d want 0", name, n_busy); end
    total++; if (n_rdy != 0) begin bad++; $display("FAIL %s cmd_ready bad_cycles=%0d want 0", name, n_rdy); end
    total++; if (n_done != 1) begin bad++; $display("FAIL %s done_count got=%0d want 1", name, n_done); end
    total++; if (done_at != DONE_J) begin bad++; $display("FAIL %s done_cycle got=%0d want %0d", name, done_at, DONE_J); end
    total++; if (n_rv != 0) begin bad++; $display("FAIL %s resp_valid bad_cycles=%0d want 0", name, n_rv); end
    total++; if (n_to != 0) begin bad++; $display("FAIL %s resp_timeout bad_cycles=%0d want 0", name, n_to); end
    total++; if (resp_frame !== '0) begin bad++; $display("FAIL %s resp_frame got=%h want 0", name, resp_frame); end
  endtask

  task automatic test_send_tx();
    run_frame("send_tx", 8'h40, 128'h41, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_frame("busy_ignore", 8'h42, rand_payload(), 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++)
      run_frame("random", ops[$urandom_range(0, 6)], rand_payload(), 1'b0);
  endtask

  task automatic test_reset_abort();
    logic [127:0] pl;
    int stop_j, n_done, n_line;
    pl = rand_payload();
    pl[39:32] = 8'h00;
    stop_j = 53 * B + 1;
    n_done = 0; n_line = 0;
    cmd_opcode = 8'h44; cmd_payload = pl; cmd_valid = 1'b1;
    for (int j = 0; j <= stop_j; j++) begin
      @(negedge clk);
      if (j == 0) cmd_valid = 1'b0;
    end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL abort_pre_tx got=%b want 0", tx); end
    #2 nreset = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL abort_async_tx got=%b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_async_busy got=%b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) n_done++;
    end
    nreset = 1'b1;
    for (int i = 0; i < 2 * B; i++) begin
      @(negedge clk);
      if (done !== 1'b0) n_done++;
      if (tx !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) n_line++;
    end
    total++; if (n_done != 0) begin bad++; $display("FAIL abort_done bad_cycles=%0d want 0", n_done); end
    total++; if (n_line != 0) begin bad++; $display("FAIL abort_idle bad_cycles=%0d want 0", n_line); end
    run_frame("after_abort", 8'h41, 128'h43, 1'b0);
  endtask

`ifdef CMD_RESP_WAIT_EN
  // Sends a command, then feeds n reply bytes from reply_b.
  task automatic test_resp(input string name, input int n);
    logic [143:0] exp_r;
    int early, k;
    exp_r = '0; early = 0; k = -1;
    cmd_opcode = 8'h62; cmd_payload = rand_payload(); cmd_valid = 1'b1;
    for (int j = 0; j <= FRAME_CLKS; j++) begin
      @(negedge clk);
      if (j == 0) cmd_valid = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        if (done !== 1'b0) early++;
      end
      rx_byte = reply_b[i]; rx_byte_valid = 1'b1;
      exp_r[i*8 +: 8] = reply_b[i];
      @(negedge clk);
      rx_byte_valid = 1'b0;
      if (i < n - 1 && done !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL %s early_done cycles=%0d want 0", name, early); end
    if (n == FB) begin
      total++; if (done !== 1'b1 || resp_valid !== 1'b1) begin bad++; $display("FAIL %s done_valid got=%b%b want 11", name, done, resp_valid); end
      total++; if (resp_timeout !== 1'b0) begin bad++; $display("FAIL %s timeout got=%b want 0", name, resp_timeout); end
    end else begin
      for (int c = 1; c <= TO + 10; c++) begin
        @(negedge clk);
        if (done === 1'b1) begin k = c; break; end
      end
      total++; if (k != TO) begin bad++; $display("FAIL %s timeout_delay got=%0d want %0d", name, k, TO); end
      total++; if (resp_timeout !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL %s timeout_flags got=%b%b want 10", name, resp_timeout, resp_valid); end
    end
    total++; if (resp_frame !== exp_r) begin bad++; $display("FAIL %s resp_frame got=%h want=%h", name, resp_frame, exp_r); end
    total++; if (resp_frame[7:0] !== reply_b[0]) begin bad++; $display("FAIL %s resp_byte0 got=%h want=%h", name, resp_frame[7:0], reply_b[0]); end
    @(negedge clk);
    total++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL %s after_done got=%b%b want 01", name, done, cmd_ready); end
  endtask

  task automatic test_resp_full();
    string s;
    s = "{hi_i'm_your_army}";
    for (int i = 0; i < FB; i++) reply_b[i] = s[i];
    test_resp("resp_full", FB);
    total++; if (resp_frame[143:136] !== 8'h7D) begin bad++; $display("FAIL resp_full byte17 got=%h want 7d", resp_frame[143:136]); end
  endtask

  task automatic test_resp_timeout();
    for (int i = 0; i < FB; i++) reply_b[i] = 8'($urandom_range(1, 255));
    test_resp("resp_timeout", 3);
  endtask
`endif

  initial begin
    ops[0] = 8'h41; ops[1] = 8'h40; ops[2] = 8'h42; ops[3] = 8'h43;
    ops[4] = 8'h44; ops[5] = 8'h61; ops[6] = 8'h62;
    test_reset();
    test_send_tx();
    test_busy_ignore();
    test_reset_abort();
    test_random();
`ifdef CMD_RESP_WAIT_EN
    test_resp_full();
    test_resp_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
